// File: rtl/prbs_checker_if.sv
// Serial PRBS checker bus: bit-stream input with valid/clear, and lock/error status out.
interface prbs_checker_if #(
  parameter int CNT_W = 16
);
  logic             en;
  logic             din;
  logic             clr;
  logic             locked;
  logic             err;
  logic             err_sticky;
  logic [CNT_W-1:0] err_cnt;

  // Stream source / status consumer side
  modport master (
    output en, din, clr,
    input  locked, err, err_sticky, err_cnt
  );

  // Checker side
  modport slave (
    input  en, din, clr,
    output locked, err, err_sticky, err_cnt
  );
endinterface

// File: rtl/prbs_checker.sv
// Receive-side PRBS checker. Self-synchronises a local LFSR to the incoming
// MSB-first bitstream, then free-runs it to predict each bit and flag errors.
// Polynomial convention matches the generator: fb = ^(s & POLY), s <= {s[W-2:0], fb}.
module prbs_checker #(
  parameter int                    LFSR_WIDTH      = 11,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLYNOMIAL = 11'b10100000000,
  parameter int                    LOCK_CNT        = 16,
  parameter int                    LOSS_ERRS       = 4,
  parameter int                    CNT_W           = 16
) (
  input  logic           clk,
  input  logic           reset,
  prbs_checker_if.slave  bus
);

  localparam int FILL_W  = $clog2(LFSR_WIDTH + 1);
  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int MISS_W  = $clog2(LOSS_ERRS + 1);

  typedef enum logic [0:0] {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [LFSR_WIDTH-1:0] r_q, r_d;
  logic [FILL_W-1:0]     fill_cnt_q, fill_cnt_d;
  logic [MATCH_W-1:0]    match_cnt_q, match_cnt_d;
  logic [MISS_W-1:0]     miss_cnt_q, miss_cnt_d;
  logic                  locked_q, locked_d;
  logic                  err_q, err_d;
  logic                  err_sticky_q, err_sticky_d;
  logic [CNT_W-1:0]      err_cnt_q, err_cnt_d;

  logic                  pred_s;
  logic                  miss_s;
  logic                  err_hit_s;
  logic [CNT_W-1:0]      err_cnt_inc_s;

  // Next-state logic: search/fill, search/compare, locked free-run, plus error accounting
  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    fill_cnt_d  = fill_cnt_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    locked_d    = locked_q;
    err_hit_s   = 1'b0;

    // With r holding the last W bits (newest at LSB), this is the generator's next bit
    pred_s = ^(r_q & LFSR_POLYNOMIAL);
    miss_s = (bus.din != pred_s);

    if (bus.en) begin
      case (state_q)
        ST_SEARCH: begin
          r_d = {r_q[LFSR_WIDTH-2:0], bus.din};
          if (fill_cnt_q != FILL_W'(LFSR_WIDTH)) begin
            fill_cnt_d = fill_cnt_q + FILL_W'(1);
          end else if (!miss_s && (r_q != {LFSR_WIDTH{1'b0}})) begin
            // The all-zero lockup window is excluded so a dead line never locks
            if (match_cnt_q == MATCH_W'(LOCK_CNT - 1)) begin
              state_d     = ST_LOCKED;
              locked_d    = 1'b1;
              match_cnt_d = {MATCH_W{1'b0}};
              miss_cnt_d  = {MISS_W{1'b0}};
            end else begin
              match_cnt_d = match_cnt_q + MATCH_W'(1);
            end
          end else begin
            match_cnt_d = {MATCH_W{1'b0}};
          end
        end
        ST_LOCKED: begin
          // Free-run on the prediction so one channel error yields exactly one err
          r_d = {r_q[LFSR_WIDTH-2:0], pred_s};
          if (miss_s) begin
            err_hit_s = 1'b1;
            if (miss_cnt_q == MISS_W'(LOSS_ERRS - 1)) begin
              state_d    = ST_SEARCH;
              locked_d   = 1'b0;
              fill_cnt_d = {FILL_W{1'b0}};
              r_d        = {LFSR_WIDTH{1'b0}};
              miss_cnt_d = {MISS_W{1'b0}};
            end else begin
              miss_cnt_d = miss_cnt_q + MISS_W'(1);
            end
          end else begin
            miss_cnt_d = {MISS_W{1'b0}};
          end
        end
        default: begin
          state_d     = ST_SEARCH;
          locked_d    = 1'b0;
          r_d         = {LFSR_WIDTH{1'b0}};
          fill_cnt_d  = {FILL_W{1'b0}};
          match_cnt_d = {MATCH_W{1'b0}};
          miss_cnt_d  = {MISS_W{1'b0}};
        end
      endcase
    end else begin
      r_d = r_q;
    end

    // Saturating increment; clr overrides any coincident error but not the pulse
    err_cnt_inc_s = (err_cnt_q == {CNT_W{1'b1}}) ? err_cnt_q : (err_cnt_q + CNT_W'(1));
    err_d         = err_hit_s;
    if (bus.clr) begin
      err_cnt_d    = {CNT_W{1'b0}};
      err_sticky_d = 1'b0;
    end else if (err_hit_s) begin
      err_cnt_d    = err_cnt_inc_s;
      err_sticky_d = 1'b1;
    end else begin
      err_cnt_d    = err_cnt_q;
      err_sticky_d = err_sticky_q;
    end
  end

  // State and registered outputs, asynchronously reset to the search state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_SEARCH;
      r_q          <= {LFSR_WIDTH{1'b0}};
      fill_cnt_q   <= {FILL_W{1'b0}};
      match_cnt_q  <= {MATCH_W{1'b0}};
      miss_cnt_q   <= {MISS_W{1'b0}};
      locked_q     <= 1'b0;
      err_q        <= 1'b0;
      err_sticky_q <= 1'b0;
      err_cnt_q    <= {CNT_W{1'b0}};
    end else begin
      state_q      <= state_d;
      r_q          <= r_d;
      fill_cnt_q   <= fill_cnt_d;
      match_cnt_q  <= match_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      locked_q     <= locked_d;
      err_q        <= err_d;
      err_sticky_q <= err_sticky_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign bus.locked     = locked_q;
  assign bus.err        = err_q;
  assign bus.err_sticky = err_sticky_q;
  assign bus.err_cnt    = err_cnt_q;

endmodule

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
- Serial receive-side counterpart of the team's LFSR/PRBS generator.
- Self-synchronises a local LFSR to an incoming serial bitstream, then predicts each following bit and flags mismatches.
- Keeps a saturating error count for link and BIST checking.
- Uses the same polynomial convention as the generator: state s, feedback fb = XOR of s[i] over all i with POLYNOMIAL[i]=1, next state {s[W-2:0], fb}, output bit = s[W-1].

Parameters:
- LFSR_WIDTH, 11: register width W, at least 3.
- LFSR_POLYNOMIAL, 11'b10100000000: tap mask, same meaning as the generator.
- LOCK_CNT, 16: consecutive correct predictions required to declare lock, at least 1.
- LOSS_ERRS, 4: consecutive mispredictions in LOCKED that cause loss of lock, at least 1.
- CNT_W, 16: error counter width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  din valid; the bit is consumed on a rising clk edge when en=1.
- din  in  1  serial data bit, MSB-first stream from the generator.
- clr  in  1  synchronous clear of err_cnt and err_sticky; effective regardless of en.
- locked  out  1  high while in LOCKED.
- err  out  1  one-cycle pulse; a mispredicted bit was consumed in LOCKED.
- err_sticky  out  1  set by any err, cleared by clr or reset.
- err_cnt  out  CNT_W  saturating count of err pulses.

Behaviour:
- Reset (asynchronous, active-high): state=SEARCH, r=0, fill_cnt=0, match_cnt=0, miss_cnt=0, locked=0, err=0, err_sticky=0, err_cnt=0.
- Prediction: pred = XOR over i of (r[i] AND POLYNOMIAL[i]). With r holding the last W received bits, newest at LSB, pred equals the generator's next output bit.
- en=0: all state holds, err=0. clr still acts.
- SEARCH, filling (fill_cnt<W):
  - Each consumed bit gives r <= {r[W-2:0], din} and fill_cnt++.
  - No comparison is made.
- SEARCH, filled (fill_cnt==W):
  - Each consumed bit is compared with pred, then r <= {r[W-2:0], din}.
  - Match with r != 0: match_cnt++.
  - Mismatch, or r==0: match_cnt <= 0. The all-zero lockup state never counts as a match.
  - When the LOCK_CNT-th consecutive match is consumed, the state becomes LOCKED on that same edge. locked=1 from that edge; match_cnt <= 0 and miss_cnt <= 0.
  - err is never asserted in SEARCH.
- LOCKED:
  - Each consumed bit gives r <= {r[W-2:0], pred}. The local LFSR free-runs, so a single channel error yields exactly one err.
  - Mismatch: err=1 for one cycle (registered, valid the cycle after the edge that consumed the bit), err_sticky <= 1, err_cnt++ saturating at 2^CNT_W-1, miss_cnt++.
  - Match: miss_cnt <= 0.
  - When the LOSS_ERRS-th consecutive mismatch is consumed, that bit still pulses err and counts. On the same edge: state <= SEARCH, locked <= 0, fill_cnt <= 0, r <= 0, miss_cnt <= 0.
- clr on the same edge as an error: clr wins, so err_cnt=0 and err_sticky=0. The err pulse itself is still output.
- Reset mid-operation: immediate return to reset values. Resynchronisation needs W + LOCK_CNT valid bits.
- Latency: locked rises at the edge consuming bit W+LOCK_CNT of a clean stream (bits numbered from 1). err follows the offending bit by 1 clk.

Test Plan:
- Clean lock: default parameters, din = generator stream seeded 11'b11011011011, en=1 continuously -> locked=1 after the edge consuming bit 27; err stays 0; err_cnt=0 after 200 bits.
- Gapped en: same stream with en toggling 1/0 every cycle -> lock after 27 consumed bits (54 cycles); no err while en=0.
- Single error: after lock, invert bit 40 -> exactly one err pulse, the cycle after bit 40; err_cnt=1; err_sticky=1; locked stays 1; no further errors.
- Loss of lock: after lock, invert bits 50–53 -> err_cnt=4; locked=0 after bit 53; relock after 27 further clean bits; err_cnt stays 4.
- Zero stream and random noise: din=0 for 300 bits -> locked never asserts. Random din for 1000 bits -> no lock with LOCK_CNT=16 for the fixed test seed.
- Saturation, clr, reset: CNT_W=3 with continuous single errors spaced 2 bits apart -> err_cnt saturates at 7. clr coincident with an error -> err_cnt=0, err_sticky=0. reset asserted mid-lock -> locked=0 and err_cnt=0 immediately, without waiting for a clk edge.
